// File: rtl/conv1_stream_sequencer_if.sv
// Input-stream and buffer write-port bundle for the conv1 sequencer; no logic.
// master = stream source / buffer side, slave = sequencer; tready backpressures the source.
interface conv1_stream_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 18
);
    logic              s_axis_in_tvalid;
    logic              s_axis_in_tready;
    logic [DATA_W-1:0] s_axis_in_tdata;
    logic              s_axis_in_tlast;

    logic              fmap_wr_en;
    logic [CNT_W-1:0]  fmap_wr_addr;
    logic [DATA_W-1:0] fmap_wr_data;
    logic              wgt_wr_en;
    logic [CNT_W-1:0]  wgt_wr_addr;
    logic [DATA_W-1:0] wgt_wr_data;

    modport master (
        output s_axis_in_tvalid, s_axis_in_tdata, s_axis_in_tlast,
        input  s_axis_in_tready,
        input  fmap_wr_en, fmap_wr_addr, fmap_wr_data,
        input  wgt_wr_en, wgt_wr_addr, wgt_wr_data
    );

    modport slave (
        input  s_axis_in_tvalid, s_axis_in_tdata, s_axis_in_tlast,
        output s_axis_in_tready,
        output fmap_wr_en, fmap_wr_addr, fmap_wr_data,
        output wgt_wr_en, wgt_wr_addr, wgt_wr_data
    );
endinterface

// File: rtl/conv1_stream_sequencer.sv
// conv1 front end: demuxes fmap then weight words into buffers (write lands 1 cycle after handshake),
// kicks the engine and waits for engine + output stream; tready only in LOAD states. Optional tlast check: CONV1_SEQ_TLAST_CHECK_EN.
module conv1_stream_sequencer #(
    parameter int DATA_W       = 8,
    parameter int FMAP_WORDS   = 37632,
    parameter int WEIGHT_WORDS = 9408,
    parameter int OUT_WORDS    = 200704,
    parameter int CNT_W        = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    output logic error,
    conv1_stream_sequencer_if.slave axis,
    output logic eng_start,
    input  logic eng_done,
    input  logic out_beat,
    input  logic out_last
);
    typedef enum logic [2:0] {IDLE, LOAD_FMAP, LOAD_WGT, KICK, RUN, FIN, ERR} state_t;

    localparam logic [CNT_W-1:0] FMAP_LAST = CNT_W'(FMAP_WORDS - 1);
    localparam logic [CNT_W-1:0] FMAP_END  = CNT_W'(FMAP_WORDS);
    localparam logic [CNT_W-1:0] WGT_LAST  = CNT_W'(WEIGHT_WORDS - 1);
    localparam logic [CNT_W-1:0] WGT_END   = CNT_W'(WEIGHT_WORDS);
    localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(OUT_WORDS - 1);
    localparam logic [CNT_W-1:0] OUT_END   = CNT_W'(OUT_WORDS);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] fmap_cnt, wgt_cnt, out_cnt;
    logic             eng_seen;
    logic             hs, tlast_bad;
    logic             fmap_we, wgt_we, cnt_clr, out_inc, out_full_nxt;

    assign hs = axis.s_axis_in_tvalid && axis.s_axis_in_tready;

`ifdef CONV1_SEQ_TLAST_CHECK_EN
    // tlast must mark exactly the final word of whichever block is loading
    always_comb begin
        tlast_bad = 1'b0;
        if (state == LOAD_FMAP)
            tlast_bad = axis.s_axis_in_tlast != (fmap_cnt == FMAP_LAST);
        else if (state == LOAD_WGT)
            tlast_bad = axis.s_axis_in_tlast != (wgt_cnt == WGT_LAST);
    end
`else
    logic tlast_unused;
    assign tlast_unused = axis.s_axis_in_tlast;
    assign tlast_bad    = 1'b0;
`endif

    assign out_full_nxt = (out_cnt == OUT_END) || (out_inc && out_cnt == OUT_LAST);

    always_comb begin
        state_nxt = state;
        fmap_we   = 1'b0;
        wgt_we    = 1'b0;
        cnt_clr   = 1'b0;
        out_inc   = 1'b0;
        case (state)
            IDLE, ERR: begin
                if (start) begin
                    cnt_clr   = 1'b1;
                    state_nxt = LOAD_FMAP;
                end
            end
            LOAD_FMAP: begin
                if (hs) begin
                    if (tlast_bad) begin
                        state_nxt = ERR;
                    end else begin
                        fmap_we = 1'b1;
                        if (fmap_cnt == FMAP_LAST) state_nxt = LOAD_WGT;
                    end
                end
            end
            LOAD_WGT: begin
                if (hs) begin
                    if (tlast_bad) begin
                        state_nxt = ERR;
                    end else begin
                        wgt_we = 1'b1;
                        if (wgt_cnt == WGT_LAST) state_nxt = KICK;
                    end
                end
            end
            KICK: state_nxt = RUN;
            RUN: begin
                // an over-run beat or a tlast on any beat but the final one is fatal
                if (out_beat && ((out_cnt == OUT_END) || (out_last && out_cnt != OUT_LAST))) begin
                    state_nxt = ERR;
                end else begin
                    out_inc = out_beat;
                    if ((eng_seen || eng_done) && out_full_nxt) state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            fmap_cnt     <= '0;
            wgt_cnt      <= '0;
            out_cnt      <= '0;
            eng_seen     <= 1'b0;
            axis.fmap_wr_en   <= 1'b0;
            axis.fmap_wr_addr <= '0;
            axis.fmap_wr_data <= '0;
            axis.wgt_wr_en    <= 1'b0;
            axis.wgt_wr_addr  <= '0;
            axis.wgt_wr_data  <= '0;
        end else begin
            state           <= state_nxt;
            axis.fmap_wr_en <= fmap_we;
            axis.wgt_wr_en  <= wgt_we;
            if (fmap_we) begin
                axis.fmap_wr_addr <= fmap_cnt;
                axis.fmap_wr_data <= axis.s_axis_in_tdata;
            end
            if (wgt_we) begin
                axis.wgt_wr_addr <= wgt_cnt;
                axis.wgt_wr_data <= axis.s_axis_in_tdata;
            end
            if (cnt_clr) begin
                fmap_cnt <= '0;
                wgt_cnt  <= '0;
                out_cnt  <= '0;
                eng_seen <= 1'b0;
            end else begin
                if (fmap_we && fmap_cnt != FMAP_END) fmap_cnt <= fmap_cnt + 1'b1;
                if (wgt_we && wgt_cnt != WGT_END)    wgt_cnt  <= wgt_cnt + 1'b1;
                if (out_inc && out_cnt != OUT_END)   out_cnt  <= out_cnt + 1'b1;
                if (state == RUN && eng_done)        eng_seen <= 1'b1;
            end
        end
    end

    assign busy                  = (state != IDLE);
    assign done                  = (state == FIN);
    assign error                 = (state == ERR);
    assign eng_start             = (state == KICK);
    assign axis.s_axis_in_tready = (state == LOAD_FMAP) || (state == LOAD_WGT);
endmodule

// File: tb/tb_conv1_stream_sequencer.sv
// Scoreboard bench for conv1_stream_sequencer with a 4-word fmap, 2-word weight, 3-beat output frame.
module tb_conv1_stream_sequencer;
    localparam int DATA_W = 8, FMAP_WORDS = 4, WEIGHT_WORDS = 2, OUT_WORDS = 3, CNT_W = 4;
    localparam int K_FMAP = 0, K_WGT = 1, K_KICK = 2, K_DONE = 3;

    logic clk = 1'b0;
    logic rst_n, start, eng_done, out_beat, out_last;
    logic busy, done, error, eng_start;

    conv1_stream_sequencer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    conv1_stream_sequencer #(
        .DATA_W(DATA_W), .FMAP_WORDS(FMAP_WORDS), .WEIGHT_WORDS(WEIGHT_WORDS),
        .OUT_WORDS(OUT_WORDS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
        .axis(bus), .eng_start(eng_start), .eng_done(eng_done),
        .out_beat(out_beat), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {int kind; int addr; int data;} exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int addr, input int data);
        exp_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        sb.push_back(e);
    endtask

    // Expected write/kick stream for a whole frame whose words are base..base+5
    task automatic push_frame(input int base);
        for (int i = 0; i < FMAP_WORDS; i++)   push(K_FMAP, i, base + i);
        for (int i = 0; i < WEIGHT_WORDS; i++) push(K_WGT, i, base + FMAP_WORDS + i);
        push(K_KICK, 0, 0);
    endtask

    task automatic mon_pop(input int kind, input int addr, input int data);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_event: got kind %0d addr %0d data %0h, expected none", kind, addr, data);
        end else begin
            e = sb.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_addr", addr, e.addr);
            chk("event_data", data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (bus.fmap_wr_en) mon_pop(K_FMAP, int'(bus.fmap_wr_addr), int'(bus.fmap_wr_data));
        if (bus.wgt_wr_en)  mon_pop(K_WGT, int'(bus.wgt_wr_addr), int'(bus.wgt_wr_data));
        if (eng_start) begin
            mon_pop(K_KICK, 0, 0);
            chk("kick_with_last_wgt_write", bus.wgt_wr_en, 1);
        end
        if (done) mon_pop(K_DONE, 0, 0);
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_start;
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input logic l, input int gap);
        bit ok = 0;
        bus.s_axis_in_tvalid = 1'b1; bus.s_axis_in_tdata = d; bus.s_axis_in_tlast = l;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); ok = bus.s_axis_in_tready;
            @(posedge clk); #1;
        end
        bus.s_axis_in_tvalid = 1'b0; bus.s_axis_in_tlast = 1'b0;
        chk("stream_handshake", ok, 1);
        cyc(gap);
    endtask

    task automatic send_frame(input int base, input int gap);
        for (int i = 0; i < FMAP_WORDS + WEIGHT_WORDS; i++)
            send_word(8'(base + i), (i == FMAP_WORDS - 1) || (i == FMAP_WORDS + WEIGHT_WORDS - 1), gap);
        cyc(1);
    endtask

    task automatic beat(input logic last, input logic ed);
        out_beat = 1'b1; out_last = last; eng_done = ed;
        cyc(1);
        out_beat = 1'b0; out_last = 1'b0; eng_done = 1'b0;
    endtask

    task automatic eng_pulse;
        eng_done = 1'b1; cyc(1); eng_done = 1'b0;
    endtask

    task automatic wait_done;
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); seen = done;
            @(posedge clk); #1;
        end
        chk("done_seen", seen, 1);
        @(negedge clk); chk("busy_after_done", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {busy, done, error, eng_start, bus.s_axis_in_tready, bus.fmap_wr_en, bus.wgt_wr_en,
                   bus.fmap_wr_addr, bus.wgt_wr_addr, bus.fmap_wr_data, bus.wgt_wr_data}, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; eng_done = 1'b0; out_beat = 1'b0; out_last = 1'b0;
        bus.s_axis_in_tvalid = 1'b0; bus.s_axis_in_tdata = '0; bus.s_axis_in_tlast = 1'b0;
        cyc(3);
        @(negedge clk); chk_all_zero("reset_outputs");
        @(posedge clk); #1; rst_n = 1'b1;
        cyc(1);

        // Nominal frame, continuous stream, engine done after the beats
        push_frame(8'h10); push(K_DONE, 0, 0);
        @(negedge clk); chk("tready_idle", bus.s_axis_in_tready, 0);
        @(posedge clk); #1;
        do_start;
        send_frame(8'h10, 0);
        @(negedge clk); chk("tready_run", bus.s_axis_in_tready, 0); chk("busy_run", busy, 1);
        @(posedge clk); #1;
        beat(0, 0); beat(0, 0); beat(1, 0);
        eng_pulse;
        wait_done;

        // tvalid gaps; engine done arrives before any beat
        push_frame(8'h20); push(K_DONE, 0, 0);
        do_start;
        send_frame(8'h20, 1);
        eng_pulse;
        beat(0, 0); beat(0, 0); beat(1, 0);
        wait_done;

        // eng_done coincident with the final beat
        push_frame(8'h30); push(K_DONE, 0, 0);
        do_start;
        send_frame(8'h30, 0);
        beat(0, 0); beat(0, 0); beat(1, 1);
        @(negedge clk); chk("sim_done_next_cycle", done, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("sim_busy_after_done", busy, 0);
        @(posedge clk); #1;

        // Over-run beat, then recovery via start
        push_frame(8'h40);
        do_start;
        send_frame(8'h40, 0);
        beat(0, 0); beat(0, 0); beat(1, 0); beat(0, 0);
        @(negedge clk);
        chk("overrun_error", error, 1); chk("overrun_busy", busy, 1);
        chk("overrun_tready", bus.s_axis_in_tready, 0);
        @(posedge clk); #1;
        push_frame(8'h50); push(K_DONE, 0, 0);
        do_start;
        @(negedge clk); chk("restart_clears_error", error, 0);
        @(posedge clk); #1;
        send_frame(8'h50, 0);
        beat(0, 0); beat(0, 0); beat(1, 1);
        wait_done;

        // tlast asserted early on fmap word 2
`ifdef CONV1_SEQ_TLAST_CHECK_EN
        push(K_FMAP, 0, 8'h60); push(K_FMAP, 1, 8'h61);
        do_start;
        for (int i = 0; i < 3; i++) send_word(8'(8'h60 + i), i == 2, 0);
        @(negedge clk);
        chk("tlast_error", error, 1); chk("tlast_no_write", bus.fmap_wr_en, 0);
        @(posedge clk); #1;
        cyc(3);
`else
        push_frame(8'h60); push(K_DONE, 0, 0);
        do_start;
        for (int i = 0; i < FMAP_WORDS + WEIGHT_WORDS; i++) send_word(8'(8'h60 + i), i == 2, 0);
        cyc(1);
        @(negedge clk); chk("tlast_ignored_no_error", error, 0);
        @(posedge clk); #1;
        beat(0, 0); beat(0, 0); beat(1, 1);
        wait_done;
`endif

        // Reset after two fmap words, then a fresh frame from address 0
        push(K_FMAP, 0, 8'h70); push(K_FMAP, 1, 8'h71);
        do_start;
        send_word(8'h70, 0, 0); send_word(8'h71, 0, 0);
        rst_n = 1'b0;
        cyc(1);
        @(negedge clk); chk_all_zero("midload_reset_outputs");
        @(posedge clk); #1; rst_n = 1'b1;
        push_frame(8'h80); push(K_DONE, 0, 0);
        do_start;
        send_frame(8'h80, 0);
        beat(0, 0); beat(0, 0); beat(1, 1);
        wait_done;

        cyc(3);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end
endmodule
